spi_reg_frontend: RTL and testbench

Upstream stage for the PWM peripheral: receives SPI Mode 0 write frames from the chip pins and holds the five 8-bit control registers (output enables, PWM enables, duty cycle) that the PWM block consumes. Asynchronous SCLK/COPI/nCS are synchronized into the system clock domain and decoded by a frame state machine. Registers change only on a complete, valid 16-bit frame.

---
 rtl/spi_reg_frontend.sv | 175 +++++++++++++++++
 tb/tb_spi_reg_frontend.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/spi_reg_frontend.sv
// spi_reg_frontend: SPI Mode 0 write-frame receiver and PWM control register bank.
// SCLK/COPI/nCS are synchronized into clk, edge-detected, and decoded by a
// four-state frame FSM. Registers change only on a complete, valid 16-bit frame.
// Optional feature macro: SPI_READBACK_EN (read frames shift register data out on cipo).
module spi_reg_frontend #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe,
  output logic       frame_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;
  localparam logic [1:0] ST_ERR   = 2'd3;

  // Storage always covers the five named outputs; addresses >= NUM_REGS are never written.
  localparam int unsigned REG_SLOTS  = (NUM_REGS > 5) ? NUM_REGS : 5;
  localparam logic [7:0]  NUM_REGS_W = 8'(NUM_REGS);

  logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync;
  logic                   sclk_d, ncs_d, copi_d;
  logic                   sclk_rise, ncs_rise, ncs_fall;
  logic [1:0]             state;
  logic [4:0]             bit_cnt;
  logic [15:0]            shift_reg;
  logic [7:0]             regs [REG_SLOTS];
  logic                   commit_wr;

  // Synchronizer chains for the three asynchronous SPI pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
    end
  end

  // Delay flops and registered edge pulses; copi_d is aligned with sclk_rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_d    <= 1'b0;
      ncs_d     <= 1'b0;
      copi_d    <= 1'b0;
      sclk_rise <= 1'b0;
      ncs_rise  <= 1'b0;
      ncs_fall  <= 1'b0;
    end else begin
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      ncs_d     <= ncs_sync[SYNC_STAGES-1];
      copi_d    <= copi_sync[SYNC_STAGES-1];
      sclk_rise <= sclk_sync[SYNC_STAGES-1] & ~sclk_d;
      ncs_rise  <= ncs_sync[SYNC_STAGES-1] & ~ncs_d;
      ncs_fall  <= ~ncs_sync[SYNC_STAGES-1] & ncs_d;
    end
  end

  assign commit_wr = shift_reg[15] && ({1'b0, shift_reg[14:8]} < NUM_REGS_W);

  // Frame FSM, shift register and register bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      for (int unsigned i = 0; i < REG_SLOTS; i++) regs[i] <= '0;
    end else begin
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ncs_fall) begin
            state     <= ST_SHIFT;
            bit_cnt   <= '0;
            shift_reg <= '0;
          end
        end
        ST_SHIFT: begin
          if (ncs_rise) begin
            frame_err <= 1'b1;
            state     <= ST_IDLE;
          end else if (sclk_rise) begin
            shift_reg <= {shift_reg[14:0], copi_d};
            bit_cnt   <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd15) state <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (ncs_rise) begin
            state <= ST_IDLE;
            if (commit_wr) begin
              wr_strobe <= 1'b1;
              for (int unsigned i = 0; i < REG_SLOTS; i++)
                if (shift_reg[14:8] == 7'(i)) regs[i] <= shift_reg[7:0];
            end
          end else if (sclk_rise) begin
            state <= ST_ERR;
          end
        end
        default: begin
          if (ncs_rise) begin
            frame_err <= 1'b1;
            state     <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign en_reg_out_7_0  = regs[0];
  assign en_reg_out_15_8 = regs[1];
  assign en_reg_pwm_7_0  = regs[2];
  assign en_reg_pwm_15_8 = regs[3];
  assign pwm_duty_cycle  = regs[4];

`ifdef SPI_READBACK_EN
  logic       sclk_fall;
  logic       rd_active;
  logic [7:0] shift_out;
  logic [6:0] rd_addr;
  logic [7:0] rd_value;

  // Falling-edge pulse, only needed to drive the shift-out register.
  always_ff @(posedge clk) begin
    if (rst) sclk_fall <= 1'b0;
    else     sclk_fall <= ~sclk_sync[SYNC_STAGES-1] & sclk_d;
  end

  // Address as it will stand once the 8th bit is shifted in.
  assign rd_addr = {shift_reg[5:0], copi_d};

  // Read mux; unimplemented addresses read as zero.
  always_comb begin
    rd_value = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      if (rd_addr == 7'(i)) rd_value = regs[i];
  end

  // MSB is held through bit 8; shifting starts at the falling edge after the 9th rise.
  always_ff @(posedge clk) begin
    if (rst || state == ST_IDLE) begin
      rd_active <= 1'b0;
      shift_out <= '0;
    end else if (state == ST_SHIFT && sclk_rise && bit_cnt == 5'd7 && !shift_reg[6]) begin
      rd_active <= 1'b1;
      shift_out <= rd_value;
    end else if (sclk_fall && rd_active && bit_cnt >= 5'd9) begin
      shift_out <= {shift_out[6:0], 1'b0};
    end
  end

  assign cipo = rd_active & shift_out[7] & (state != ST_IDLE);
`else
  assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_frontend.sv
// Scoreboard bench for spi_reg_frontend: stimulus pushes expected strobe/error
// events (with register snapshot and due cycle); a monitor pops on each pulse.
module tb_spi_reg_frontend;

  logic       clk = 1'b0;
  logic       rst, sclk, copi, ncs;
  logic       cipo, wr_strobe, frame_err;
  logic [7:0] r0, r1, r2, r3, r4;

  spi_reg_frontend #(.SYNC_STAGES(2), .NUM_REGS(5)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs), .cipo(cipo),
    .en_reg_out_7_0(r0), .en_reg_out_15_8(r1), .en_reg_pwm_7_0(r2),
    .en_reg_pwm_15_8(r3), .pwm_duty_cycle(r4),
    .wr_strobe(wr_strobe), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          err;
    logic [39:0] regs;
    int unsigned due;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [39:0] exp_regs = '0;
  bit          cipo_seen = 1'b0;

  wire [39:0] dut_regs = {r4, r3, r2, r1, r0};

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe or error pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && cipo) cipo_seen = 1'b1;
    if (!rst && (wr_strobe || frame_err)) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event: got wr_strobe=%0b frame_err=%0b, required no event (cyc %0d)",
                 wr_strobe, frame_err, cyc);
      end else begin
        e = q.pop_front();
        if (wr_strobe !== !e.err || frame_err !== e.err || dut_regs !== e.regs || cyc != e.due) begin
          n_bad++;
          $display("FAIL event: got ws=%0b fe=%0b regs=%h cyc=%0d, required ws=%0b fe=%0b regs=%h cyc=%0d",
                   wr_strobe, frame_err, dut_regs, cyc, !e.err, e.err, e.regs, e.due);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // kind: 0 = no event, 1 = write of val into register idx, 2 = frame error.
  task automatic do_frame(input logic [31:0] bits, input int nbits, input int kind,
                          input int idx, input logic [7:0] val, input bit rst_mid,
                          output logic [7:0] rd_byte);
    exp_t e;
    rd_byte = '0;
    ncs = 1'b0;
    wait_clk(8);
    for (int k = 0; k < nbits; k++) begin
      copi = bits[nbits-1-k];
      wait_clk(8);
      if (k >= 8 && k < 16) rd_byte = {rd_byte[6:0], cipo};
      sclk = 1'b1;
      wait_clk(8);
      sclk = 1'b0;
      if (rst_mid && k == 7) begin
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        exp_regs = '0;
      end
    end
    wait_clk(8);
    if (kind == 1) exp_regs[idx*8 +: 8] = val;
    if (kind != 0) begin
      e.err  = (kind == 2);
      e.regs = exp_regs;
      e.due  = cyc + 4;
      q.push_back(e);
    end
    ncs = 1'b1;
    wait_clk(16);
    check("pending_events", 64'(q.size()), 64'd0);
    check("regs", 64'(dut_regs), 64'(exp_regs));
  endtask

  logic [7:0] rd;
  logic [7:0] exp_rd;

  initial begin
    rst = 1'b1; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(8);
    check("reset_state", 64'({dut_regs, wr_strobe, frame_err, cipo}), 64'd0);

    do_frame(32'h80F0, 16, 1, 0, 8'hF0, 1'b0, rd);
    check("r0_after_80F0", 64'(r0), 64'hF0);
    do_frame(32'h8480, 16, 1, 4, 8'h80, 1'b0, rd);
    do_frame(32'h8433, 16, 1, 4, 8'h33, 1'b0, rd);
    check("duty_after_8433", 64'(r4), 64'h33);
    do_frame(32'h8512, 16, 0, 0, 8'h00, 1'b0, rd);
    do_frame(32'h0812, 12, 2, 0, 8'h00, 1'b0, rd);
    do_frame(32'h101E1, 17, 2, 0, 8'h00, 1'b0, rd);
    do_frame(32'h83AA, 16, 0, 0, 8'h00, 1'b1, rd);
    check("regs_after_reset", 64'(dut_regs), 64'd0);
    do_frame(32'h83AA, 16, 1, 3, 8'hAA, 1'b0, rd);
    check("r3_after_83AA", 64'(r3), 64'hAA);
    do_frame(32'h81C3, 16, 1, 1, 8'hC3, 1'b0, rd);
    do_frame(32'h8255, 16, 1, 2, 8'h55, 1'b0, rd);
    do_frame(32'h845A, 16, 1, 4, 8'h5A, 1'b0, rd);
    do_frame(32'h0400, 16, 0, 0, 8'h00, 1'b0, rd);
`ifdef SPI_READBACK_EN
    exp_rd = 8'h5A;
`else
    exp_rd = 8'h00;
    check("cipo_never_high", 64'(cipo_seen), 64'd0);
`endif
    check("readback_0400", 64'(rd), 64'(exp_rd));
    do_frame(32'h0183, 16, 0, 0, 8'h00, 1'b0, rd);
`ifdef SPI_READBACK_EN
    exp_rd = 8'hC3;
`endif
    check("readback_0183", 64'(rd), 64'(exp_rd));
    do_frame(32'h0700, 16, 0, 0, 8'h00, 1'b0, rd);
    check("readback_unimpl", 64'(rd), 64'd0);

    wait_clk(10);
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
